// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered, flow-controlled RV32I/RV64I immediate decode FIFO.
// Define IMM_GEN_CSR_ZIMM_EN to decode CSR*I immediates as zero-extended zimm (type 6).
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_imm,
  output logic [2:0]             out_type,
  output logic                   out_illegal,
  output logic [XLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam bit RV64 = (XLEN == 64);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {T_I, T_S, T_B, T_U, T_J, T_R, T_Z, T_ILL} imm_type_e;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_OP32  = 7'b0111011;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic            is_shift;
  imm_type_e       dec_type;
  logic [XLEN-1:0] dec_imm;

  assign op       = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign imm_i    = XLEN'($signed(in_instr[31:20]));
  assign imm_s    = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b    = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u    = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j    = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign is_shift = (op == OP_IMM || op == OP_IMM32) && f3[1:0] == 2'b01;
  // 6-bit shamt only for full-width RV64 shifts; the W forms stay 5-bit
  assign shamt    = (RV64 && op == OP_IMM) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);

  always_comb begin
    dec_type = T_ILL;
    dec_imm  = '0;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: begin dec_type = T_I; dec_imm = imm_i; end
      OP_IMM32: if (RV64) begin dec_type = T_I; dec_imm = imm_i; end
`ifdef IMM_GEN_CSR_ZIMM_EN
      OP_SYS: begin
        dec_type = f3[2] ? T_Z : T_I;
        dec_imm  = f3[2] ? XLEN'(in_instr[19:15]) : imm_i;
      end
`else
      OP_SYS: begin dec_type = T_I; dec_imm = imm_i; end
`endif
      OP_STORE: begin dec_type = T_S; dec_imm = imm_s; end
      OP_BR: begin dec_type = T_B; dec_imm = imm_b; end
      OP_LUI, OP_AUIPC: begin dec_type = T_U; dec_imm = imm_u; end
      OP_JAL: begin dec_type = T_J; dec_imm = imm_j; end
      OP_OP, OP_FENCE: dec_type = T_R;
      OP_OP32: if (RV64) dec_type = T_R;
      default: ;
    endcase
    if (is_shift && dec_type == T_I) dec_imm = shamt;
  end

  logic [XLEN-1:0] imm_q  [DEPTH];
  imm_type_e       type_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign in_ready  = count_q < CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d    = flush ? '0 : push ? inc(wr_q) : wr_q;
    rd_d    = flush ? '0 : pop ? inc(rd_q) : rd_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[wr_q]  <= dec_imm;
      type_q[wr_q] <= dec_type;
      pc_q[wr_q]   <= in_pc;
    end
  end

  assign out_imm     = out_valid ? imm_q[rd_q] : '0;
  assign out_type    = out_valid ? type_q[rd_q] : 3'd0;
  assign out_illegal = out_valid && type_q[rd_q] == T_ILL;
  assign out_pc      = out_valid ? pc_q[rd_q] : '0;
  assign count       = count_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed checks of imm_gen_stage at XLEN=32 and XLEN=64 sharing stimulus.
module tb_imm_gen_stage;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_pc;
  logic [2:0]  out_type;
  logic [1:0]  count;
  logic        rdy64, val64, ill64;
  logic [63:0] imm64, pc64;
  logic [2:0]  type64;
  logic [1:0]  cnt64;
  int          errors = 0, checks = 0;
  logic [31:0] pc = 32'h1000;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_type(out_type), .out_illegal(out_illegal), .out_pc(out_pc),
    .count(count)
  );

  imm_gen_stage #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc({32'h0, in_pc}), .out_valid(val64), .out_ready(out_ready),
    .out_imm(imm64), .out_type(type64), .out_illegal(ill64), .out_pc(pc64),
    .count(cnt64)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s instr=%h: got %h expected %h", tag, in_instr, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] ins, input logic [31:0] e32, input logic [2:0] t32,
                      input logic [63:0] e64, input logic [2:0] t64);
    in_instr = ins; in_pc = pc; in_valid = 1; out_ready = 0;
    tick;
    in_valid = 0;
    check("valid", out_valid, 1);
    check("imm32", out_imm, e32);
    check("type32", out_type, t32);
    check("ill32", out_illegal, t32 == 3'd7);
    check("pc", out_pc, pc);
    check("imm64", imm64, e64);
    check("type64", type64, t64);
    check("ill64", ill64, t64 == 3'd7);
    out_ready = 1;
    tick;
    out_ready = 0;
    check("drain", count, 0);
    pc += 4;
  endtask

  initial begin
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_imm", out_imm, 0);
    check("rst_type", out_type, 0);
    rst_n = 1;
    tick;
    xfer(32'hFFF00093, 32'hFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 0);
    xfer(32'hFE112E23, 32'hFFFFFFFC, 1, 64'hFFFFFFFFFFFFFFFC, 1);
    xfer(32'hFE000CE3, 32'hFFFFFFF8, 2, 64'hFFFFFFFFFFFFFFF8, 2);
    xfer(32'h4030D093, 32'h3, 0, 64'h3, 0);
    xfer(32'h0000007F, 32'h0, 7, 64'h0, 7);
    xfer(32'h800000B7, 32'h80000000, 3, 64'hFFFFFFFF80000000, 3);
    xfer(32'hFFDFF06F, 32'hFFFFFFFC, 4, 64'hFFFFFFFFFFFFFFFC, 4);
    xfer(32'h002081B3, 32'h0, 5, 64'h0, 5);
    xfer(32'hFFF0809B, 32'h0, 7, 64'hFFFFFFFFFFFFFFFF, 0);
    xfer(32'h002080BB, 32'h0, 7, 64'h0, 5);
    xfer(32'h02109093, 32'h1, 0, 64'h21, 0);
`ifdef IMM_GEN_CSR_ZIMM_EN
    xfer(32'h300FD073, 32'h1F, 6, 64'h1F, 6);
`else
    xfer(32'h300FD073, 32'h300, 0, 64'h300, 0);
`endif
    in_instr = 32'h00100093; out_ready = 0; in_valid = 1;
    in_pc = 32'h100; tick;
    check("bp_cnt1", count, 1);
    check("bp_rdy1", in_ready, 1);
    in_pc = 32'h104; tick;
    check("bp_cnt2", count, 2);
    check("bp_rdy2", in_ready, 0);
    check("bp_headA", out_pc, 32'h100);
    in_pc = 32'h108; tick;
    check("bp_held", count, 2);
    out_ready = 1; tick;
    check("bp_pop_cnt", count, 1);
    check("bp_headB", out_pc, 32'h104);
    tick;
    check("bp_steady1", count, 1);
    check("bp_headC", out_pc, 32'h108);
    in_pc = 32'h10C; tick;
    check("bp_steady2", count, 1);
    check("bp_headD", out_pc, 32'h10C);
    in_valid = 0; tick;
    check("bp_empty", count, 0);
    out_ready = 0; in_valid = 1;
    in_pc = 32'h200; tick;
    in_pc = 32'h204; tick;
    check("fl_full", count, 2);
    flush = 1; in_pc = 32'h208; tick;
    flush = 0; in_valid = 0;
    check("fl_count", count, 0);
    check("fl_valid", out_valid, 0);
    check("fl_imm", out_imm, 0);
    check("fl_pc", out_pc, 0);
    check("fl_ready", in_ready, 1);
    tick;
    check("fl_lost", count, 0);
    in_valid = 1; in_pc = 32'h300; tick;
    in_valid = 0;
    check("ar_pre", count, 1);
    #2 rst_n = 0;
    #1;
    check("ar_count", count, 0);
    check("ar_valid", out_valid, 0);
    check("ar_count64", cnt64, 0);
    #3 rst_n = 1;
    tick;
    check("ar_after", count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
